alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 8-bit ALU.
- Captures each ALU result into a small FIFO and presents it to the register file over a valid/ready handshake.
- Holds the architectural carry, zero and parity flags; the carry flag is fed back to the ALU shift_carry input.
- Converts the ALU branch-condition output into a one-cycle branch_taken pulse.

Parameters:
DEPTH, 2, writeback FIFO entries (power of 2, >= 2)
ADDR_W, 3, register-file address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage can accept (FIFO not full)
alu_cmd  input  3  opcode that produced the result
rslt  input  8  ALU result
sc_o  input  1  ALU carry out
absj  input  1  ALU branch condition (meaningful for alu_cmd 010 only)
wr_en_in  input  1  instruction writes the register file
wr_addr_in  input  ADDR_W  destination register
flag_clr  input  1  synchronous clear of all flags
out_valid  output  1  writeback entry available
out_ready  input  1  register file consumes the head entry
wb_data  output  8  head entry data
wb_addr  output  ADDR_W  head entry destination
carry_flag  output  1  carry flag, drives ALU sc_i
zero_flag  output  1  result-was-zero flag
pari_flag  output  1  result parity flag
branch_taken  output  1  one-cycle pulse
occupancy  output  clog2(DEPTH)+1  entries held

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, async): FIFO emptied; pointers, occupancy, all flags and branch_taken = 0. out_valid = 0, wb_data = 0, wb_addr = 0. in_ready = 1 from the first edge after release.
- Accept: accept = in_valid & in_ready; all side effects occur on that rising edge. in_valid while in_ready = 0 is dropped: no flag or FIFO effect; upstream must hold.
- in_ready = (occupancy < DEPTH), combinational from registered state only, with no in_valid-to-in_ready path.
- Enqueue: on accept with wr_en_in = 1 and alu_cmd != 010, write {rslt, wr_addr_in} at the tail. Otherwise nothing is enqueued.
- Dequeue: pop = out_valid & out_ready. out_valid = (occupancy != 0).
- wb_data and wb_addr come from the head entry. They stay stable while out_valid = 1 and out_ready = 0. When empty, both are 0.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. Push is allowed when full only if it is not accepted; in_ready already gates it, so there is no full-and-pop bypass.
- Pointers wrap modulo DEPTH.
- Flags update on accept only. Zero and parity are computed locally from rslt (zero = rslt == 0, parity = XOR-reduce of rslt); the ALU's own zero/pari outputs are not used.
  - alu_cmd 111 (add): carry <= sc_o; zero and parity updated.
  - alu_cmd 011, 100, 101 (xor, rotate, and): zero and parity updated; carry held.
  - alu_cmd 010 (branch test): no flag change. branch_taken = 1 in the cycle after accept iff absj = 1; otherwise 0.
  - Other opcodes (000, 001, 110): no flag change, no branch. Writeback is still enqueued if wr_en_in = 1.
- flag_clr: clears carry, zero and parity on the next edge. If an accept with a flag-updating opcode occurs in the same cycle, the accept's update wins for the flags it writes; flags it does not write are cleared.
- branch_taken is a registered pulse, exactly one cycle per qualifying accept. Back-to-back qualifying accepts hold it high on consecutive cycles.
- Flags are independent of FIFO state: accepting a wr_en_in = 0 add still updates carry.
- Reset mid-operation: any held entries and a pending branch_taken are discarded immediately (async).

Test Plan:
- Reset, then accept add (rslt = 8'h00, sc_o = 1, wr_en_in = 1, addr 5) -> next cycle carry_flag = 1, zero_flag = 1, pari_flag = 0, out_valid = 1, wb_data = 00, wb_addr = 5, occupancy = 1.
- out_ready = 0; accept xor 8'h07 to addr 2, then attempt a third input -> occupancy = 2, in_ready = 0, third input ignored. Head stays 00/5 until out_ready = 1, then 07/2. pari_flag = 1, carry_flag still 1.
- Full FIFO with out_ready = 1 and in_valid = 1 held -> steady 1 push/1 pop per cycle after in_ready recovers; data order preserved across pointer wrap (8 entries 01..08).
- alu_cmd 010 with absj = 1, then absj = 0 -> branch_taken high exactly one cycle after the first accept only; no FIFO entry, flags unchanged.
- flag_clr asserted in the same cycle as accepted add (sc_o = 1, rslt = 8'h80) -> carry = 1, zero = 0, parity = 1. flag_clr alone the next cycle -> all flags 0.
- rst_n dropped asynchronously mid-cycle with occupancy = 2 and branch_taken = 1 -> outputs 0 before the next edge; in_ready = 1 after release.

Source files
------------

// File: rtl/alu_wb_stage_if.sv
// Bus between the ALU-side producer, the writeback stage and the register file.
// The master drives ALU results and the register-file ready; the slave (the
// stage) returns the writeback head entry, the flags and the branch pulse.
interface alu_wb_stage_if #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 3
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // ALU result side
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_cmd;
    logic [7:0]        rslt;
    logic              sc_o;
    logic              absj;
    logic              wr_en_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic              flag_clr;

    // Register-file writeback side
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        wb_data;
    logic [ADDR_W-1:0] wb_addr;

    // Architectural state
    logic              carry_flag;
    logic              zero_flag;
    logic              pari_flag;
    logic              branch_taken;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output in_valid, alu_cmd, rslt, sc_o, absj, wr_en_in, wr_addr_in,
               flag_clr, out_ready,
        input  in_ready, out_valid, wb_data, wb_addr, carry_flag, zero_flag,
               pari_flag, branch_taken, occupancy
    );

    modport slave (
        input  in_valid, alu_cmd, rslt, sc_o, absj, wr_en_in, wr_addr_in,
               flag_clr, out_ready,
        output in_ready, out_valid, wb_data, wb_addr, carry_flag, zero_flag,
               pari_flag, branch_taken, occupancy
    );
endinterface

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results in a small FIFO toward the
// register file, keeps the carry/zero/parity flags and turns the ALU branch
// condition into a one-cycle branch_taken pulse.
module alu_wb_stage #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_wb_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] CMD_BRANCH = 3'b010;
    localparam logic [2:0] CMD_XOR    = 3'b011;
    localparam logic [2:0] CMD_ROT    = 3'b100;
    localparam logic [2:0] CMD_AND    = 3'b101;
    localparam logic [2:0] CMD_ADD    = 3'b111;

    // FIFO storage; contents need no reset because the head is masked when empty
    logic [7:0]        mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              pari_q, pari_d;
    logic              branch_q, branch_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic              is_branch;

    // Readiness depends on registered occupancy only, never on in_valid
    assign bus.in_ready  = (occ_q < OCC_W'(DEPTH));
    assign bus.out_valid = (occ_q != '0);

    assign accept    = bus.in_valid & bus.in_ready;
    assign is_branch = (bus.alu_cmd == CMD_BRANCH);
    assign push      = accept & bus.wr_en_in & ~is_branch;
    assign pop       = bus.out_valid & bus.out_ready;

    assign bus.wb_data      = bus.out_valid ? mem_data_q[rd_ptr_q] : 8'h00;
    assign bus.wb_addr      = bus.out_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign bus.occupancy    = occ_q;
    assign bus.carry_flag   = carry_q;
    assign bus.zero_flag    = zero_q;
    assign bus.pari_flag    = pari_q;
    assign bus.branch_taken = branch_q;

    // Next pointer/occupancy: push and pop together leave occupancy unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Next flags: clear first, then an accepted opcode overrides what it writes
    always_comb begin
        carry_d  = carry_q;
        zero_d   = zero_q;
        pari_d   = pari_q;
        branch_d = accept & is_branch & bus.absj;
        if (bus.flag_clr) begin
            carry_d = 1'b0;
            zero_d  = 1'b0;
            pari_d  = 1'b0;
        end
        if (accept) begin
            case (bus.alu_cmd)
                CMD_ADD: begin
                    carry_d = bus.sc_o;
                    zero_d  = ~|bus.rslt;
                    pari_d  = ^bus.rslt;
                end
                CMD_XOR, CMD_ROT, CMD_AND: begin
                    zero_d = ~|bus.rslt;
                    pari_d = ^bus.rslt;
                end
                default: ;
            endcase
        end
    end

    // Control and flag state, discarded immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            pari_q   <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            pari_q   <= pari_d;
            branch_q <= branch_d;
        end
    end

    // Write the accepted result into the tail entry
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= bus.rslt;
            mem_addr_q[wr_ptr_q] <= bus.wr_addr_in;
        end
    end
endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a queue-based model.
module tb_alu_wb_stage;
    localparam int DEPTH  = 2;
    localparam int ADDR_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_wb_stage_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    alu_wb_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending writebacks plus plain flag bits
    logic [7:0]        m_data [$];
    logic [ADDR_W-1:0] m_addr [$];
    logic m_carry = 1'b0, m_zero = 1'b0, m_par = 1'b0, m_br = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit acc, deq;
        if (!rst_n) begin
            m_data.delete();
            m_addr.delete();
            m_carry = 1'b0; m_zero = 1'b0; m_par = 1'b0; m_br = 1'b0;
        end else begin
            acc  = bus.in_valid && (m_data.size() < DEPTH);
            deq  = (m_data.size() != 0) && bus.out_ready;
            m_br = acc && (bus.alu_cmd == 3'd2) && bus.absj;
            if (bus.flag_clr) begin
                m_carry = 1'b0; m_zero = 1'b0; m_par = 1'b0;
            end
            if (acc) begin
                if (bus.alu_cmd == 3'd7) m_carry = bus.sc_o;
                if (bus.alu_cmd inside {3'd3, 3'd4, 3'd5, 3'd7}) begin
                    m_zero = (bus.rslt == 8'd0);
                    m_par  = ^bus.rslt;
                end
            end
            if (deq) begin
                void'(m_data.pop_front());
                void'(m_addr.pop_front());
            end
            if (acc && bus.wr_en_in && bus.alu_cmd != 3'd2) begin
                m_data.push_back(bus.rslt);
                m_addr.push_back(bus.wr_addr_in);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [7:0]        ed;
        logic [ADDR_W-1:0] ea;
        ed = (m_data.size() != 0) ? m_data[0] : 8'h00;
        ea = (m_addr.size() != 0) ? m_addr[0] : '0;
        chk("m_in_ready",  32'(bus.in_ready),     32'(m_data.size() < DEPTH));
        chk("m_out_valid", 32'(bus.out_valid),    32'(m_data.size() != 0));
        chk("m_occupancy", 32'(bus.occupancy),    32'(m_data.size()));
        chk("m_wb_data",   32'(bus.wb_data),      32'(ed));
        chk("m_wb_addr",   32'(bus.wb_addr),      32'(ea));
        chk("m_carry",     32'(bus.carry_flag),   32'(m_carry));
        chk("m_zero",      32'(bus.zero_flag),    32'(m_zero));
        chk("m_parity",    32'(bus.pari_flag),    32'(m_par));
        chk("m_branch",    32'(bus.branch_taken), 32'(m_br));
    end

    task automatic set_in(input logic v, input logic [2:0] cmd, input logic [7:0] r,
                          input logic sc, input logic aj, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic clr, input logic ordy);
        bus.in_valid   = v;
        bus.alu_cmd    = cmd;
        bus.rslt       = r;
        bus.sc_o       = sc;
        bus.absj       = aj;
        bus.wr_en_in   = wr;
        bus.wr_addr_in = a;
        bus.flag_clr   = clr;
        bus.out_ready  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_occ"},   32'(bus.occupancy),    32'd0);
        chk({tag, "_ov"},    32'(bus.out_valid),    32'd0);
        chk({tag, "_data"},  32'(bus.wb_data),      32'd0);
        chk({tag, "_addr"},  32'(bus.wb_addr),      32'd0);
        chk({tag, "_carry"}, 32'(bus.carry_flag),   32'd0);
        chk({tag, "_zero"},  32'(bus.zero_flag),    32'd0);
        chk({tag, "_par"},   32'(bus.pari_flag),    32'd0);
        chk({tag, "_br"},    32'(bus.branch_taken), 32'd0);
    endtask

    logic [7:0] got [$];
    int         nxt;
    bit         acc_now;

    initial begin
        set_in(0, 3'd0, 8'h00, 0, 0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #1 rst_n = 1'b1;
        tick();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // add 00 with carry to r5
        set_in(1, 3'd7, 8'h00, 1, 0, 1, 3'd5, 0, 0);
        tick();
        chk("add_carry", 32'(bus.carry_flag), 32'd1);
        chk("add_zero",  32'(bus.zero_flag),  32'd1);
        chk("add_par",   32'(bus.pari_flag),  32'd0);
        chk("add_ov",    32'(bus.out_valid),  32'd1);
        chk("add_data",  32'(bus.wb_data),    32'h00);
        chk("add_addr",  32'(bus.wb_addr),    32'd5);
        chk("add_occ",   32'(bus.occupancy),  32'd1);

        // xor 07 to r2 fills the FIFO; a third input must be dropped
        set_in(1, 3'd3, 8'h07, 0, 0, 1, 3'd2, 0, 0);
        tick();
        chk("full_occ",   32'(bus.occupancy), 32'd2);
        chk("full_rdy",   32'(bus.in_ready),  32'd0);
        chk("xor_par",    32'(bus.pari_flag), 32'd1);
        chk("xor_carry",  32'(bus.carry_flag), 32'd1);
        set_in(1, 3'd7, 8'h55, 0, 0, 1, 3'd7, 0, 0);
        tick();
        chk("drop_occ",   32'(bus.occupancy),  32'd2);
        chk("drop_carry", 32'(bus.carry_flag), 32'd1);
        chk("drop_par",   32'(bus.pari_flag),  32'd1);
        chk("hold_data",  32'(bus.wb_data),    32'h00);
        chk("hold_addr",  32'(bus.wb_addr),    32'd5);
        set_in(0, 3'd0, 8'h00, 0, 0, 0, '0, 0, 1);
        tick();
        chk("pop1_data", 32'(bus.wb_data),   32'h07);
        chk("pop1_addr", 32'(bus.wb_addr),   32'd2);
        chk("pop1_occ",  32'(bus.occupancy), 32'd1);
        tick();
        chk("pop2_ov",   32'(bus.out_valid), 32'd0);
        chk("pop2_data", 32'(bus.wb_data),   32'h00);

        // fill, then stream 8 entries through with in_valid held
        set_in(1, 3'd0, 8'h01, 0, 0, 1, 3'd1, 0, 0);
        tick();
        set_in(1, 3'd0, 8'h02, 0, 0, 1, 3'd2, 0, 0);
        tick();
        nxt = 3;
        got.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            bus.in_valid   = (nxt <= 8);
            bus.rslt       = 8'(nxt);
            bus.wr_addr_in = ADDR_W'(nxt);
            acc_now = bus.in_valid && bus.in_ready;
            if (bus.out_valid) got.push_back(bus.wb_data);
            tick();
            if (acc_now) nxt++;
        end
        chk("stream_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("stream_order", 32'(got[i]), 32'(i + 1));

        // branch test: absj=1 pulses once, absj=0 does not
        set_in(1, 3'd2, 8'hAA, 1, 1, 1, 3'd3, 0, 1);
        tick();
        chk("br1_pulse", 32'(bus.branch_taken), 32'd1);
        chk("br1_occ",   32'(bus.occupancy),    32'd0);
        set_in(1, 3'd2, 8'h00, 1, 0, 1, 3'd3, 0, 1);
        tick();
        chk("br0_pulse", 32'(bus.branch_taken), 32'd0);
        chk("br0_carry", 32'(bus.carry_flag),   32'd1);
        chk("br0_zero",  32'(bus.zero_flag),    32'd0);
        chk("br0_par",   32'(bus.pari_flag),    32'd1);

        // flag_clr against concurrent updates
        set_in(1, 3'd7, 8'h80, 1, 0, 0, '0, 1, 1);
        tick();
        chk("clradd_carry", 32'(bus.carry_flag), 32'd1);
        chk("clradd_zero",  32'(bus.zero_flag),  32'd0);
        chk("clradd_par",   32'(bus.pari_flag),  32'd1);
        set_in(1, 3'd3, 8'h00, 0, 0, 0, '0, 1, 1);
        tick();
        chk("clrxor_carry", 32'(bus.carry_flag), 32'd0);
        chk("clrxor_zero",  32'(bus.zero_flag),  32'd1);
        chk("clrxor_par",   32'(bus.pari_flag),  32'd0);
        set_in(0, 3'd0, 8'h00, 0, 0, 0, '0, 1, 1);
        tick();
        chk("clr_carry", 32'(bus.carry_flag), 32'd0);
        chk("clr_zero",  32'(bus.zero_flag),  32'd0);
        chk("clr_par",   32'(bus.pari_flag),  32'd0);

        // async reset with two held entries
        set_in(1, 3'd7, 8'h01, 1, 0, 1, 3'd4, 0, 0);
        tick();
        set_in(1, 3'd0, 8'h02, 0, 0, 1, 3'd6, 0, 0);
        tick();
        chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
        set_in(0, 3'd0, 8'h00, 0, 0, 0, '0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("arst_full");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_rdy", 32'(bus.in_ready), 32'd1);

        // async reset with a pending branch pulse
        set_in(1, 3'd0, 8'h33, 0, 0, 1, 3'd1, 0, 0);
        tick();
        set_in(1, 3'd2, 8'h00, 0, 1, 0, '0, 0, 0);
        tick();
        chk("pre_rst_br", 32'(bus.branch_taken), 32'd1);
        set_in(0, 3'd0, 8'h00, 0, 0, 0, '0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("arst_br");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // randomized traffic, checked by the every-cycle model compare
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom % 4) != 0, 3'($urandom % 8), 8'($urandom),
                   1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) != 0,
                   ADDR_W'($urandom), ($urandom % 8) == 0, 1'($urandom % 2));
            if (c == 300) begin
                #3 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
            tick();
        end

        set_in(0, 3'd0, 8'h00, 0, 0, 0, '0, 0, 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
